// File: rtl/vram_arb_pkg.sv
// vram_arb_pkg: grant encoding, default widths and write FIFO entry
// shared by the VRAM arbiter files (optional VRAM_ARB_STARVE_EN in top).
package vram_arb_pkg;

   localparam int VRAM_ADDR_W = 20;
   localparam int VRAM_DATA_W = 8;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_DISP = 2'd1,
      GNT_WR   = 2'd2
   } grant_t;

   typedef struct packed {
      logic [VRAM_ADDR_W-1:0] addr;
      logic [VRAM_DATA_W-1:0] data;
   } wr_entry_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: display read, CPU write and VRAM port bundle.
// master = requesters + VRAM side, slave = the arbiter.
interface vram_arbiter_if #(
   parameter int ADDR_W = 20,
   parameter int DATA_W = 8
) ();

   logic              disp_req;
   logic [ADDR_W-1:0] disp_addr;
   logic [DATA_W-1:0] disp_data;
   logic              disp_valid;
   logic              disp_miss;

   logic              cpu_wr_req;
   logic [ADDR_W-1:0] cpu_wr_addr;
   logic [DATA_W-1:0] cpu_wr_data;
   logic              cpu_wr_ready;

   logic [ADDR_W-1:0] vram_address;
   logic              vram_w_enable;
   logic [DATA_W-1:0] vram_w_data;
   logic [DATA_W-1:0] vram_r_data;

   modport master (
      output disp_req, disp_addr,
      input  disp_data, disp_valid, disp_miss,
      output cpu_wr_req, cpu_wr_addr, cpu_wr_data,
      input  cpu_wr_ready,
      input  vram_address, vram_w_enable, vram_w_data,
      output vram_r_data
   );

   modport slave (
      input  disp_req, disp_addr,
      output disp_data, disp_valid, disp_miss,
      input  cpu_wr_req, cpu_wr_addr, cpu_wr_data,
      output cpu_wr_ready,
      output vram_address, vram_w_enable, vram_w_data,
      input  vram_r_data
   );

endinterface

// File: rtl/vram_wr_fifo.sv
// vram_wr_fifo: synchronous FIFO of wr_entry_t, FIFO_DEPTH entries.
// Ports: clk, rst (async low), push, pop, din, dout (head), full, empty.
module vram_wr_fifo
   import vram_arb_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      push,
   input  logic      pop,
   input  wr_entry_t din,
   output wr_entry_t dout,
   output logic      full,
   output logic      empty
);

   localparam int PW = $clog2(FIFO_DEPTH);

   wr_entry_t     mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   assign full  = (count == (PW+1)'(FIFO_DEPTH));
   assign empty = (count == '0);
   assign dout  = mem[rd_ptr];

   // Depth is a power of two, so pointers wrap by overflow.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: count alone marks entries valid.
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one VRAM port between display reads and
// buffered CPU writes. Ports: clk, rst (async low), bus (slave).
// Optional `VRAM_ARB_STARVE_EN: forces a write after STARVE_LIMIT
// blocked cycles and reports the denied read on disp_miss.
module vram_arbiter
   import vram_arb_pkg::*;
#(
   parameter int ADDR_W       = 20,
   parameter int DATA_W       = 8,
   parameter int FIFO_DEPTH   = 4,
   parameter int STARVE_LIMIT = 15
) (
   input logic            clk,
   input logic            rst,
   vram_arbiter_if.slave  bus
);

   if (FIFO_DEPTH < 2 ||
       (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two >= 2");
   end

   if (STARVE_LIMIT < 1) begin : g_bad_limit
      $error("STARVE_LIMIT must be >= 1");
   end

   if (ADDR_W > VRAM_ADDR_W ||
       DATA_W > VRAM_DATA_W) begin : g_bad_width
      $error("ADDR_W/DATA_W exceed the FIFO entry widths");
   end

   grant_t    gnt;
   grant_t    last_gnt;
   wr_entry_t din;
   wr_entry_t head;
   logic      full;
   logic      empty;
   logic      wr_gnt;
   logic      force_wr;

   assign din.addr = VRAM_ADDR_W'(bus.cpu_wr_addr);
   assign din.data = VRAM_DATA_W'(bus.cpu_wr_data);

   vram_wr_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (bus.cpu_wr_req),
      .pop   (wr_gnt),
      .din   (din),
      .dout  (head),
      .full  (full),
      .empty (empty)
   );

   // Items overlap, so first match wins.
   always_comb begin
      gnt = GNT_NONE;
      priority case (1'b1)
         force_wr:     gnt = GNT_WR;
         bus.disp_req: gnt = GNT_DISP;
         !empty:       gnt = GNT_WR;
         default:      gnt = GNT_NONE;
      endcase
   end

   assign wr_gnt = (gnt == GNT_WR);

   assign bus.cpu_wr_ready  = !full;
   assign bus.vram_w_enable = wr_gnt && rst;
   assign bus.vram_w_data   = wr_gnt ?
                              DATA_W'(head.data) : '0;
   assign bus.vram_address  = wr_gnt ?
                              ADDR_W'(head.addr) :
                              bus.disp_addr;

   // VRAM read data lags the address by one cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         last_gnt <= GNT_NONE;
      else
         last_gnt <= gnt;
   end

   assign bus.disp_valid = (last_gnt == GNT_DISP);
   assign bus.disp_data  = bus.disp_valid ?
                           bus.vram_r_data : '0;

`ifdef VRAM_ARB_STARVE_EN
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   logic [SW-1:0] starve_cnt;
   logic          miss_q;

   assign force_wr = bus.disp_req && !empty &&
                     (starve_cnt == SW'(STARVE_LIMIT));

   // Counts display wins over a waiting write; the forced
   // write at the limit clears it, so it never overflows.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_cnt <= '0;
         miss_q     <= 1'b0;
      end else begin
         miss_q <= force_wr;
         if (empty || wr_gnt)
            starve_cnt <= '0;
         else if (gnt == GNT_DISP)
            starve_cnt <= starve_cnt + SW'(1);
      end
   end

   assign bus.disp_miss = miss_q;
`else
   assign force_wr      = 1'b0;
   assign bus.disp_miss = 1'b0;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: vector table, corner sequences and random
// traffic against a queue-based model of the arbiter.
module tb_vram_arbiter;

   localparam int AW    = 20;
   localparam int DW    = 8;
   localparam int DEPTH = 4;
   localparam int LIMIT = 15;

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   vram_arbiter #(
      .ADDR_W       (AW),
      .DATA_W       (DW),
      .FIFO_DEPTH   (DEPTH),
      .STARVE_LIMIT (LIMIT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // VRAM: registered read, one cycle of latency.
   logic [DW-1:0] vmem [logic [AW-1:0]];
   logic [DW-1:0] env_r;

   always @(posedge clk) begin
      env_r = vmem.exists(bus.vram_address) ?
              vmem[bus.vram_address] : '0;
      if (bus.vram_w_enable)
         vmem[bus.vram_address] = bus.vram_w_data;
      bus.vram_r_data <= env_r;
   end

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } ent_t;

   ent_t          q [$];
   logic [DW-1:0] mm [logic [AW-1:0]];
   bit            m_prev_disp;
   bit            m_prev_miss;
   logic [DW-1:0] m_prev_rd;
   int            m_cnt;
   bit            m_wr;
   bit            m_force;
   bit            starve_en;

   int errors = 0;
   int checks = 0;

   bit            obs_we;
   logic [AW-1:0] obs_a;
   logic [DW-1:0] obs_wd;
   bit            obs_v;
   logic [DW-1:0] obs_d;
   bit            obs_rdy;
   bit            obs_miss;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h @%0t",
                  nm, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] rdmem(input logic [AW-1:0] a);
      return mm.exists(a) ? mm[a] : '0;
   endfunction

   task automatic model_reset();
      q.delete();
      m_prev_disp = 0;
      m_prev_miss = 0;
      m_prev_rd   = '0;
      m_cnt       = 0;
   endtask

   task automatic model_check();
      bit            ew;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      m_force = starve_en && bus.disp_req &&
                q.size() > 0 && m_cnt == LIMIT;
      m_wr = m_force || (!bus.disp_req && q.size() > 0);
      if (m_wr) begin
         ew = 1; ea = q[0].a; ed = q[0].d;
      end else begin
         ew = 0; ea = bus.disp_addr; ed = '0;
      end
      chk("w_enable", bus.vram_w_enable, ew);
      chk("address", bus.vram_address, ea);
      chk("w_data", bus.vram_w_data, ed);
      chk("wr_ready", bus.cpu_wr_ready, q.size() < DEPTH);
      chk("disp_valid", bus.disp_valid, m_prev_disp);
      chk("disp_data", bus.disp_data,
          m_prev_disp ? m_prev_rd : '0);
      chk("disp_miss", bus.disp_miss, m_prev_miss);
   endtask

   task automatic model_update();
      bit   had;
      bit   was_full;
      bit   disp_g;
      ent_t e;
      had      = q.size() > 0;
      was_full = q.size() == DEPTH;
      disp_g   = bus.disp_req && !m_force;
      if (disp_g)
         m_prev_rd = rdmem(bus.disp_addr);
      if (m_wr) begin
         mm[q[0].a] = q[0].d;
         void'(q.pop_front());
      end
      if (bus.cpu_wr_req && !was_full) begin
         e.a = bus.cpu_wr_addr;
         e.d = bus.cpu_wr_data;
         q.push_back(e);
      end
      m_prev_disp = disp_g;
      m_prev_miss = m_force;
      if (!had || m_wr)
         m_cnt = 0;
      else if (disp_g)
         m_cnt++;
   endtask

   task automatic cyc(input bit rq, input logic [AW-1:0] ra,
                      input bit wq, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd);
      bus.disp_req    = rq;
      bus.disp_addr   = ra;
      bus.cpu_wr_req  = wq;
      bus.cpu_wr_addr = wa;
      bus.cpu_wr_data = wd;
      @(negedge clk);
      obs_we   = bus.vram_w_enable;
      obs_a    = bus.vram_address;
      obs_wd   = bus.vram_w_data;
      obs_v    = bus.disp_valid;
      obs_d    = bus.disp_data;
      obs_rdy  = bus.cpu_wr_ready;
      obs_miss = bus.disp_miss;
      model_check();
      @(posedge clk);
      model_update();
      #1;
   endtask

   typedef struct {
      bit            rq;
      logic [AW-1:0] ra;
      bit            wq;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      bit            e_we;
      logic [AW-1:0] e_a;
      logic [DW-1:0] e_wd;
      bit            e_v;
      logic [DW-1:0] e_d;
      bit            e_rdy;
   } vec_t;

   vec_t tbl [15];

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
`ifdef VRAM_ARB_STARVE_EN
      starve_en = 1;
`else
      starve_en = 0;
`endif
      // Idle write, then fill under display priority,
      // full-and-pop, and in-order drain.
      tbl[0]  = '{0, 20'h0,   1, 20'h123, 8'hA5,
                  0, 20'h0,   8'h00, 0, 8'h00, 1};
      tbl[1]  = '{0, 20'h0,   0, 20'h0,   8'h00,
                  1, 20'h123, 8'hA5, 0, 8'h00, 1};
      tbl[2]  = '{0, 20'h0,   0, 20'h0,   8'h00,
                  0, 20'h0,   8'h00, 0, 8'h00, 1};
      tbl[3]  = '{1, 20'h10,  1, 20'h200, 8'h01,
                  0, 20'h10,  8'h00, 0, 8'h00, 1};
      tbl[4]  = '{1, 20'h11,  1, 20'h201, 8'h02,
                  0, 20'h11,  8'h00, 1, 8'h3C, 1};
      tbl[5]  = '{1, 20'h12,  1, 20'h202, 8'h03,
                  0, 20'h12,  8'h00, 1, 8'h00, 1};
      tbl[6]  = '{1, 20'h13,  1, 20'h203, 8'h04,
                  0, 20'h13,  8'h00, 1, 8'h00, 1};
      tbl[7]  = '{1, 20'h14,  1, 20'h204, 8'h05,
                  0, 20'h14,  8'h00, 1, 8'h00, 0};
      tbl[8]  = '{0, 20'h0,   1, 20'h204, 8'h05,
                  1, 20'h200, 8'h01, 1, 8'h00, 0};
      tbl[9]  = '{1, 20'h10,  1, 20'h204, 8'h05,
                  0, 20'h10,  8'h00, 0, 8'h00, 1};
      tbl[10] = '{0, 20'h0,   0, 20'h0,   8'h00,
                  1, 20'h201, 8'h02, 1, 8'h3C, 0};
      tbl[11] = '{0, 20'h0,   0, 20'h0,   8'h00,
                  1, 20'h202, 8'h03, 0, 8'h00, 1};
      tbl[12] = '{0, 20'h0,   0, 20'h0,   8'h00,
                  1, 20'h203, 8'h04, 0, 8'h00, 1};
      tbl[13] = '{0, 20'h0,   0, 20'h0,   8'h00,
                  1, 20'h204, 8'h05, 0, 8'h00, 1};
      tbl[14] = '{0, 20'h0,   0, 20'h0,   8'h00,
                  0, 20'h0,   8'h00, 0, 8'h00, 1};

      vmem[20'h10]    = 8'h3C;
      mm[20'h10]      = 8'h3C;
      bus.vram_r_data = '0;

      // Requests held during reset must not reach VRAM.
      rst             = 0;
      bus.disp_req    = 1;
      bus.disp_addr   = 20'h10;
      bus.cpu_wr_req  = 1;
      bus.cpu_wr_addr = 20'h777;
      bus.cpu_wr_data = 8'h99;
      @(negedge clk);
      @(negedge clk);
      chk("reset_we", bus.vram_w_enable, 0);
      chk("reset_valid", bus.disp_valid, 0);
      chk("reset_ready", bus.cpu_wr_ready, 1);
      chk("reset_miss", bus.disp_miss, 0);
      chk("reset_data", bus.disp_data, 0);
      chk("reset_wdata", bus.vram_w_data, 0);
      @(posedge clk);
      #1;
      rst = 1;
      model_reset();

      // First read after reset: valid one cycle later.
      cyc(1, 20'h10, 0, 20'h0, 8'h00);
      chk("first_req_novalid", obs_v, 0);
      cyc(0, 20'h0, 0, 20'h0, 8'h00);
      chk("first_valid", obs_v, 1);
      chk("first_data", obs_d, 8'h3C);

      for (int i = 0; i < 15; i++) begin
         cyc(tbl[i].rq, tbl[i].ra, tbl[i].wq,
             tbl[i].wa, tbl[i].wd);
         chk($sformatf("vec%0d_we", i), obs_we, tbl[i].e_we);
         chk($sformatf("vec%0d_addr", i), obs_a, tbl[i].e_a);
         chk($sformatf("vec%0d_wdata", i), obs_wd, tbl[i].e_wd);
         chk($sformatf("vec%0d_valid", i), obs_v, tbl[i].e_v);
         chk($sformatf("vec%0d_data", i), obs_d, tbl[i].e_d);
         chk($sformatf("vec%0d_ready", i), obs_rdy, tbl[i].e_rdy);
      end

`ifdef VRAM_ARB_STARVE_EN
      begin
         int n;
         n = 0;
         cyc(1, 20'h10, 1, 20'h300, 8'h77);
         for (int i = 1; i <= 40; i++) begin
            cyc(1, 20'h10, 0, 20'h0, 8'h00);
            if (obs_we) begin
               n = i;
               break;
            end
         end
         chk("starve_force_cycle", n, LIMIT + 1);
         cyc(1, 20'h10, 0, 20'h0, 8'h00);
         chk("starve_miss", obs_miss, 1);
         chk("starve_novalid", obs_v, 0);
         cyc(1, 20'h10, 0, 20'h0, 8'h00);
         chk("starve_miss_clear", obs_miss, 0);
      end
`endif

      // Reset with pending writes and a read in flight.
      for (int i = 0; i < 3; i++)
         cyc(1, 20'h10, 1, AW'(20'h40 + i), DW'(8'h50 + i));
      bus.disp_req   = 1;
      bus.cpu_wr_req = 1;
      #2;
      rst = 0;
      #1;
      chk("midrst_we", bus.vram_w_enable, 0);
      chk("midrst_valid", bus.disp_valid, 0);
      chk("midrst_ready", bus.cpu_wr_ready, 1);
      @(posedge clk);
      #1;
      rst = 1;
      model_reset();
      cyc(0, 20'h0, 0, 20'h0, 8'h00);
      chk("midrst_dropped", obs_we, 0);

      for (int i = 0; i < 3000; i++) begin
         int pct;
         pct = ((i / 500) % 2 == 0) ? 80 : 30;
         cyc($urandom_range(0, 99) < pct,
             AW'($urandom_range(0, 63)),
             $urandom_range(0, 1) == 1,
             AW'($urandom_range(0, 63)),
             DW'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
